axi_rd_arb: RTL and testbench

AXI_RD_ARB -- requirements
Module: axi_rd_arb

---
 rtl/axi_rd_arb.sv | 198 +++++++++++++++++++
 tb/tb_axi_rd_arb.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arb.sv
// Round-robin arbiter sharing one AXI read channel between LSU (0) and loader (1).
// AR: combinational grant in IDLE, registered request held until accepted; R: one-entry buffer per requester, routed by rid[7].
module axi_rd_arb #(
    parameter int CNT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rq0_arid,
    input  logic [9:0]  rq0_araddr,
    input  logic [7:0]  rq0_arlen,
    input  logic [2:0]  rq0_arsize,
    input  logic [1:0]  rq0_arburst,
    input  logic [2:0]  rq0_arstr,
    input  logic        rq0_arvld,
    output logic        rq0_arrdy,
    output logic [7:0]  rq0_rid,
    output logic [63:0] rq0_rdata,
    output logic [1:0]  rq0_rresp,
    output logic        rq0_rlast,
    output logic        rq0_rvld,
    input  logic        rq0_rrdy,
    input  logic [7:0]  rq1_arid,
    input  logic [9:0]  rq1_araddr,
    input  logic [7:0]  rq1_arlen,
    input  logic [2:0]  rq1_arsize,
    input  logic [1:0]  rq1_arburst,
    input  logic [2:0]  rq1_arstr,
    input  logic        rq1_arvld,
    output logic        rq1_arrdy,
    output logic [7:0]  rq1_rid,
    output logic [63:0] rq1_rdata,
    output logic [1:0]  rq1_rresp,
    output logic        rq1_rlast,
    output logic        rq1_rvld,
    input  logic        rq1_rrdy,
    output logic [7:0]  arb_axi_arid,
    output logic [9:0]  arb_axi_araddr,
    output logic [7:0]  arb_axi_arlen,
    output logic [2:0]  arb_axi_arsize,
    output logic [1:0]  arb_axi_arburst,
    output logic [2:0]  arb_axi_arstr,
    output logic        arb_axi_arvld,
    input  logic        axi_arb_arrdy,
    input  logic [7:0]  axi_arb_rid,
    input  logic [63:0] axi_arb_rdata,
    input  logic [1:0]  axi_arb_rresp,
    input  logic        axi_arb_rlast,
    input  logic        axi_arb_rvld,
    output logic        arb_axi_rrdy
);
    typedef enum logic {IDLE, HOLD} state_t;

    typedef struct packed {
        logic [7:0] arid;
        logic [9:0] araddr;
        logic [7:0] arlen;
        logic [2:0] arsize;
        logic [1:0] arburst;
        logic [2:0] arstr;
    } ar_t;

    typedef struct packed {
        logic [7:0]  rid;
        logic [63:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
    } rbeat_t;

    localparam logic [3:0] CNT_LIM = 4'(CNT_MAX);

    state_t            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              owner_q, owner_d;
    ar_t               ar_q, ar_d;
    logic [1:0][3:0]   cnt_q, cnt_d;
    rbeat_t [1:0]      buf_q, buf_d;
    logic [1:0]        buf_vld_q, buf_vld_d;

    ar_t [1:0]         rq_ar;
    logic [1:0]        rq_arvld, rq_rrdy, elig;
    logic              gnt, gnt_vld, ar_acc, rsp_tgt, rsp_hs;

    assign rq_ar[0] = {rq0_arid, rq0_araddr, rq0_arlen, rq0_arsize, rq0_arburst, rq0_arstr};
    assign rq_ar[1] = {rq1_arid, rq1_araddr, rq1_arlen, rq1_arsize, rq1_arburst, rq1_arstr};
    assign rq_arvld = {rq1_arvld, rq0_arvld};
    assign rq_rrdy  = {rq1_rrdy, rq0_rrdy};
    assign elig[0]  = rq_arvld[0] && (cnt_q[0] < CNT_LIM);
    assign elig[1]  = rq_arvld[1] && (cnt_q[1] < CNT_LIM);

    // Tie goes to whoever was not granted last; otherwise the lone eligible requester.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = 1'b0;
        if (state_q == IDLE) begin
            if (elig[0] && elig[1]) begin
                gnt_vld = 1'b1;
                gnt     = ~last_gnt_q;
            end else if (elig[0] || elig[1]) begin
                gnt_vld = 1'b1;
                gnt     = elig[1];
            end
        end
    end

    assign rq0_arrdy = gnt_vld & ~gnt;
    assign rq1_arrdy = gnt_vld & gnt;
    assign ar_acc    = (state_q == HOLD) && axi_arb_arrdy;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        owner_d    = owner_q;
        ar_d       = ar_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    ar_d       = rq_ar[gnt];
                    ar_d.arid  = {gnt, rq_ar[gnt].arid[6:0]};
                    last_gnt_d = gnt;
                    owner_d    = gnt;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (axi_arb_arrdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_tgt      = axi_arb_rid[7];
    assign arb_axi_rrdy = ~buf_vld_q[rsp_tgt] | rq_rrdy[rsp_tgt];
    assign rsp_hs       = axi_arb_rvld & arb_axi_rrdy;

    // A load into a buffer wins over a drain in the same cycle, so the new beat stays valid.
    always_comb begin
        buf_d     = buf_q;
        buf_vld_d = buf_vld_q;
        cnt_d     = cnt_q;
        for (int n = 0; n < 2; n++) begin
            logic load, inc, dec;
            load = rsp_hs && (rsp_tgt == 1'(n));
            inc  = ar_acc && (owner_q == 1'(n));
            dec  = load && axi_arb_rlast;
            if (load) begin
                buf_d[n]     = {1'b0, axi_arb_rid[6:0], axi_arb_rdata, axi_arb_rresp, axi_arb_rlast};
                buf_vld_d[n] = 1'b1;
            end else if (buf_vld_q[n] && rq_rrdy[n]) begin
                buf_vld_d[n] = 1'b0;
            end
            if (inc && !dec && cnt_q[n] != CNT_LIM) begin
                cnt_d[n] = cnt_q[n] + 4'd1;
            end else if (dec && !inc && cnt_q[n] != 4'd0) begin
                cnt_d[n] = cnt_q[n] - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            owner_q    <= 1'b0;
            ar_q       <= '0;
            cnt_q      <= '0;
            buf_q      <= '0;
            buf_vld_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            owner_q    <= owner_d;
            ar_q       <= ar_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            buf_vld_q  <= buf_vld_d;
        end
    end

    assign arb_axi_arvld   = (state_q == HOLD);
    assign arb_axi_arid    = ar_q.arid;
    assign arb_axi_araddr  = ar_q.araddr;
    assign arb_axi_arlen   = ar_q.arlen;
    assign arb_axi_arsize  = ar_q.arsize;
    assign arb_axi_arburst = ar_q.arburst;
    assign arb_axi_arstr   = ar_q.arstr;

    assign rq0_rvld  = buf_vld_q[0];
    assign rq0_rid   = buf_q[0].rid;
    assign rq0_rdata = buf_q[0].rdata;
    assign rq0_rresp = buf_q[0].rresp;
    assign rq0_rlast = buf_q[0].rlast;
    assign rq1_rvld  = buf_vld_q[1];
    assign rq1_rid   = buf_q[1].rid;
    assign rq1_rdata = buf_q[1].rdata;
    assign rq1_rresp = buf_q[1].rresp;
    assign rq1_rlast = buf_q[1].rlast;

endmodule

// File: tb/tb_axi_rd_arb.sv
// Bench for axi_rd_arb: random requesters and downstream slave, scoreboarded against a transaction-level model.
module tb_axi_rd_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  rq0_arid = '0, rq1_arid = '0;
    logic [9:0]  rq0_araddr = '0, rq1_araddr = '0;
    logic [7:0]  rq0_arlen = '0, rq1_arlen = '0;
    logic [2:0]  rq0_arsize = '0, rq1_arsize = '0;
    logic [1:0]  rq0_arburst = '0, rq1_arburst = '0;
    logic [2:0]  rq0_arstr = '0, rq1_arstr = '0;
    logic        rq0_arvld = 1'b0, rq1_arvld = 1'b0;
    logic        rq0_arrdy, rq1_arrdy;
    logic [7:0]  rq0_rid, rq1_rid;
    logic [63:0] rq0_rdata, rq1_rdata;
    logic [1:0]  rq0_rresp, rq1_rresp;
    logic        rq0_rlast, rq1_rlast, rq0_rvld, rq1_rvld;
    logic        rq0_rrdy = 1'b0, rq1_rrdy = 1'b0;
    logic [7:0]  arb_axi_arid, arb_axi_arlen;
    logic [9:0]  arb_axi_araddr;
    logic [2:0]  arb_axi_arsize, arb_axi_arstr;
    logic [1:0]  arb_axi_arburst;
    logic        arb_axi_arvld, arb_axi_rrdy;
    logic        axi_arb_arrdy = 1'b0;
    logic [7:0]  axi_arb_rid = '0;
    logic [63:0] axi_arb_rdata = '0;
    logic [1:0]  axi_arb_rresp = '0;
    logic        axi_arb_rlast = 1'b0, axi_arb_rvld = 1'b0;

    axi_rd_arb #(.CNT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .rq0_arid(rq0_arid), .rq0_araddr(rq0_araddr), .rq0_arlen(rq0_arlen), .rq0_arsize(rq0_arsize),
        .rq0_arburst(rq0_arburst), .rq0_arstr(rq0_arstr), .rq0_arvld(rq0_arvld), .rq0_arrdy(rq0_arrdy),
        .rq0_rid(rq0_rid), .rq0_rdata(rq0_rdata), .rq0_rresp(rq0_rresp), .rq0_rlast(rq0_rlast),
        .rq0_rvld(rq0_rvld), .rq0_rrdy(rq0_rrdy),
        .rq1_arid(rq1_arid), .rq1_araddr(rq1_araddr), .rq1_arlen(rq1_arlen), .rq1_arsize(rq1_arsize),
        .rq1_arburst(rq1_arburst), .rq1_arstr(rq1_arstr), .rq1_arvld(rq1_arvld), .rq1_arrdy(rq1_arrdy),
        .rq1_rid(rq1_rid), .rq1_rdata(rq1_rdata), .rq1_rresp(rq1_rresp), .rq1_rlast(rq1_rlast),
        .rq1_rvld(rq1_rvld), .rq1_rrdy(rq1_rrdy),
        .arb_axi_arid(arb_axi_arid), .arb_axi_araddr(arb_axi_araddr), .arb_axi_arlen(arb_axi_arlen),
        .arb_axi_arsize(arb_axi_arsize), .arb_axi_arburst(arb_axi_arburst), .arb_axi_arstr(arb_axi_arstr),
        .arb_axi_arvld(arb_axi_arvld), .axi_arb_arrdy(axi_arb_arrdy),
        .axi_arb_rid(axi_arb_rid), .axi_arb_rdata(axi_arb_rdata), .axi_arb_rresp(axi_arb_rresp),
        .axi_arb_rlast(axi_arb_rlast), .axi_arb_rvld(axi_arb_rvld), .arb_axi_rrdy(arb_axi_rrdy)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic pct(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    // Reference model: one request in flight at a time, outstanding bursts per requester,
    // alternating tie-break, and per-requester queues of beats handed over but not yet consumed.
    bit          m_busy;
    int          m_last;
    int          m_out[2];
    logic [33:0] ar_q[$];
    logic [74:0] r0_q[$];
    logic [74:0] r1_q[$];

    always @(negedge clk) begin
        int   g;
        logic t;
        logic e0, e1, exp_rrdy;
        if (!rst_n) begin
            m_busy = 0; m_last = 1; m_out[0] = 0; m_out[1] = 0;
            ar_q.delete(); r0_q.delete(); r1_q.delete();
        end else begin
            e0 = rq0_arvld && m_out[0] < 15;
            e1 = rq1_arvld && m_out[1] < 15;
            g = -1;
            if (!m_busy) begin
                if (e0 && e1) g = 1 - m_last;
                else if (e0) g = 0;
                else if (e1) g = 1;
            end
            chk("rq0_arrdy", rq0_arrdy, g == 0);
            chk("rq1_arrdy", rq1_arrdy, g == 1);
            chk("arb_axi_arvld", arb_axi_arvld, m_busy);
            if (arb_axi_arvld && ar_q.size() > 0)
                chk("ar_fields", {arb_axi_arid, arb_axi_araddr, arb_axi_arlen, arb_axi_arsize,
                                  arb_axi_arburst, arb_axi_arstr}, ar_q[0]);
            if (m_busy && axi_arb_arrdy && ar_q.size() > 0) begin
                m_out[ar_q[0][33]]++;
                ar_q.delete(0);
                m_busy = 0;
            end
            if (g == 0) ar_q.push_back({1'b0, rq0_arid[6:0], rq0_araddr, rq0_arlen, rq0_arsize, rq0_arburst, rq0_arstr});
            if (g == 1) ar_q.push_back({1'b1, rq1_arid[6:0], rq1_araddr, rq1_arlen, rq1_arsize, rq1_arburst, rq1_arstr});
            if (g >= 0) begin m_busy = 1; m_last = g; end

            t = axi_arb_rid[7];
            exp_rrdy = t ? (r1_q.size() == 0 || rq1_rrdy) : (r0_q.size() == 0 || rq0_rrdy);
            if (axi_arb_rvld) chk("arb_axi_rrdy", arb_axi_rrdy, exp_rrdy);
            chk("rq0_rvld", rq0_rvld, r0_q.size() != 0);
            chk("rq1_rvld", rq1_rvld, r1_q.size() != 0);
            if (rq0_rvld && r0_q.size() > 0) chk("rq0_beat", {rq0_rid, rq0_rdata, rq0_rresp, rq0_rlast}, r0_q[0]);
            if (rq1_rvld && r1_q.size() > 0) chk("rq1_beat", {rq1_rid, rq1_rdata, rq1_rresp, rq1_rlast}, r1_q[0]);
            if (rq0_rvld && rq0_rrdy && r0_q.size() > 0) r0_q.delete(0);
            if (rq1_rvld && rq1_rrdy && r1_q.size() > 0) r1_q.delete(0);
            if (axi_arb_rvld && arb_axi_rrdy) begin
                if (t) r1_q.push_back({1'b0, axi_arb_rid[6:0], axi_arb_rdata, axi_arb_rresp, axi_arb_rlast});
                else   r0_q.push_back({1'b0, axi_arb_rid[6:0], axi_arb_rdata, axi_arb_rresp, axi_arb_rlast});
                if (axi_arb_rlast && m_out[t] > 0) m_out[t]--;
            end
        end
    end

    // Stimulus knobs (percent) and the downstream slave's list of accepted bursts.
    int   p_req0, p_req1, p_ardy, p_rsp, p_rrdy0, p_rrdy1;
    bit   fix_id1;
    logic [7:0] sl_id[$];
    int   sl_beats[$];
    int   beats_sent;
    logic smp_arrdy0, smp_arrdy1, smp_arvld, seen;
    logic [7:0] smp_arid;

    task automatic step();
        logic hs0, hs1, r_hs;
        @(negedge clk);
        hs0 = rq0_arvld & rq0_arrdy;
        hs1 = rq1_arvld & rq1_arrdy;
        r_hs = axi_arb_rvld & arb_axi_rrdy;
        smp_arrdy0 = rq0_arrdy; smp_arrdy1 = rq1_arrdy;
        smp_arvld = arb_axi_arvld; smp_arid = arb_axi_arid;
        if (arb_axi_arvld && axi_arb_arrdy) begin
            sl_id.push_back(arb_axi_arid);
            sl_beats.push_back(int'(arb_axi_arlen) + 1);
        end
        @(posedge clk);
        #1;
        if (!rq0_arvld || hs0) begin
            rq0_arvld = pct(p_req0); rq0_arid = 8'($urandom); rq0_araddr = 10'($urandom);
            rq0_arlen = 8'($urandom_range(0, 3)); rq0_arsize = 3'($urandom);
            rq0_arburst = 2'($urandom); rq0_arstr = 3'($urandom);
        end
        if (!rq1_arvld || hs1) begin
            rq1_arvld = pct(p_req1); rq1_arid = fix_id1 ? 8'h05 : 8'($urandom); rq1_araddr = 10'($urandom);
            rq1_arlen = 8'($urandom_range(0, 3)); rq1_arsize = 3'($urandom);
            rq1_arburst = 2'($urandom); rq1_arstr = 3'($urandom);
        end
        axi_arb_arrdy = pct(p_ardy);
        rq0_rrdy = pct(p_rrdy0);
        rq1_rrdy = pct(p_rrdy1);
        if (r_hs) begin
            beats_sent++;
            if (axi_arb_rlast && sl_id.size() > 0) begin
                sl_id.delete(0); sl_beats.delete(0); beats_sent = 0;
            end
        end
        if (!axi_arb_rvld || r_hs) begin
            if (sl_id.size() > 0 && pct(p_rsp)) begin
                axi_arb_rvld = 1'b1;
                axi_arb_rid = sl_id[0];
                axi_arb_rdata = {$urandom, $urandom};
                axi_arb_rresp = 2'($urandom);
                axi_arb_rlast = (beats_sent == sl_beats[0] - 1);
            end else begin
                axi_arb_rvld = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sl_id.delete(); sl_beats.delete(); beats_sent = 0;
        axi_arb_rvld = 1'b0;
        #1;
        chk("rst_arvld", arb_axi_arvld, 0);
        chk("rst_rvld0", rq0_rvld, 0);
        chk("rst_rvld1", rq1_rvld, 0);
        chk("rst_ar_regs", {arb_axi_arid, arb_axi_araddr, arb_axi_arlen, arb_axi_arsize,
                            arb_axi_arburst, arb_axi_arstr}, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic set_knobs(input int r0, input int r1, input int ar, input int rs, input int d0, input int d1);
        p_req0 = r0; p_req1 = r1; p_ardy = ar; p_rsp = rs; p_rrdy0 = d0; p_rrdy1 = d1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fix_id1 = 0;
        beats_sent = 0;
        // Both requesting from reset with a ready slave: grants alternate starting at 0.
        set_knobs(100, 100, 100, 0, 100, 100);
        rq0_arvld = 1'b1; rq1_arvld = 1'b1; axi_arb_arrdy = 1'b1;
        #2;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            chk("alt_arvld", smp_arvld, (i % 2) == 1);
            if (i % 2 == 0) begin
                chk("alt_gnt0", smp_arrdy0, ((i / 2) % 2) == 0);
                chk("alt_gnt1", smp_arrdy1, ((i / 2) % 2) == 1);
            end else begin
                chk("alt_arid7", smp_arid[7], ((i / 2) % 2) == 1);
            end
        end
        set_knobs(0, 0, 100, 100, 100, 100);
        repeat (60) step();

        // Requester 0 saturates at 15 outstanding bursts, then resumes after one completes.
        set_knobs(100, 0, 100, 0, 100, 100);
        repeat (40) step();
        chk("sat_arrdy0", smp_arrdy0, 0);
        chk("sat_down_idle", smp_arvld, 0);
        p_rsp = 100;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            seen = smp_arrdy0;
        end
        chk("sat_resume", seen, 1);
        set_knobs(0, 0, 100, 100, 100, 100);
        repeat (200) step();

        // Random traffic with backpressure everywhere.
        set_knobs(60, 60, 50, 60, 50, 50);
        repeat (3000) step();
        set_knobs(0, 0, 100, 100, 100, 100);
        repeat (300) step();
        chk("drain_ar", ar_q.size(), 0);
        chk("drain_r0", r0_q.size(), 0);
        chk("drain_r1", r1_q.size(), 0);
        chk("drain_slave", sl_id.size(), 0);

        // Stalled downstream holds requester 1's request; reset mid-hold drops it.
        fix_id1 = 1;
        set_knobs(0, 100, 0, 0, 100, 100);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = smp_arvld;
        end
        chk("hold_seen", seen, 1);
        p_req0 = 100;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_arvld", smp_arvld, 1);
            chk("hold_arid", smp_arid, 8'h85);
            chk("hold_arrdy0", smp_arrdy0, 0);
        end
        @(negedge clk);
        #2;
        do_reset();
        step();
        chk("post_rst_gnt0", smp_arrdy0, 1);
        chk("post_rst_gnt1", smp_arrdy1, 0);
        fix_id1 = 0;
        set_knobs(0, 0, 100, 100, 100, 100);
        repeat (60) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
